// File: rtl/fpadd_share_arb_pkg.sv
// Shared types and helpers for the fp16 adder sharing arbiter.
package fpadd_share_arb_pkg;

  localparam int FP16_W  = 16;
  localparam int MAX_N   = 8;
  localparam int MAX_IDW = 3;

  // One slot of the tag pipeline: valid bit plus owning requester.
  typedef struct packed {
    logic               v;
    logic [MAX_IDW-1:0] id;
  } tag_t;

  // Pull requester idx's operand out of a zero-extended packed operand bus.
  function automatic logic [FP16_W-1:0] fp16_slice(
    input logic [FP16_W*MAX_N-1:0] bus,
    input int                      idx
  );
    return bus[idx*FP16_W +: FP16_W];
  endfunction

endpackage

// File: rtl/fpadd_share_arb_if.sv
// Requester, shared-adder and response signals of the fp16 adder arbiter.
interface fpadd_share_arb_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  // Request transfer happens in a cycle where req_valid[i] & req_ready[i];
  // req_valid may drop before a grant, and responses have no backpressure.
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [15:0]     add_a;
  logic [15:0]     add_b;
  logic [15:0]     add_sum;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_sum;

  modport slave (
    input  req_valid, req_a, req_b, add_sum,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

  modport master (
    output req_valid, req_a, req_b, add_sum,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/fpadd_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr, mod N.
module fpadd_share_arb_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int i;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    i      = 0;
    for (int k = 0; k < N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!any && valid[i]) begin
        any       = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/fpadd_share_arb.sv
// Round-robin sharing of one registered fp16 adder among N requesters,
// returning each sum tagged with its requester ID after LAT cycles.
module fpadd_share_arb
  import fpadd_share_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int LAT = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           en,
  fpadd_share_arb_if.slave bus,
  output logic           idle,
  output logic [IDW-1:0] dbg_ptr
);

  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          ptr_next;
  logic [IDW-1:0]          pick_idx;
  logic [N-1:0]            pick_onehot;
  logic                    pick_any;
  logic                    grant_ok;
  logic                    grant_any;
  logic [FP16_W*MAX_N-1:0] a_ext;
  logic [FP16_W*MAX_N-1:0] b_ext;
  logic                    inflight;
  tag_t                    stage [LAT];

  fpadd_share_arb_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .valid  (bus.req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grants are suppressed while RESET is high, not only after the flops clear.
  assign grant_ok      = en & ~RESET;
  assign grant_any     = pick_any & grant_ok;
  assign bus.req_ready = grant_ok ? pick_onehot : '0;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[FP16_W*N-1:0] = bus.req_a;
    b_ext[FP16_W*N-1:0] = bus.req_b;
  end

  assign bus.add_a = grant_any ? fp16_slice(a_ext, int'(pick_idx)) : '0;
  assign bus.add_b = grant_any ? fp16_slice(b_ext, int'(pick_idx)) : '0;

  assign ptr_next = (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= ptr_next;
    end
  end

  // Tag pipeline mirrors the adder latency so the ID lines up with add_sum.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < LAT; k++) stage[k] <= '0;
    end else begin
      stage[0] <= '{v: grant_any, id: MAX_IDW'(pick_idx)};
      for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k < LAT; k++) inflight = inflight | stage[k].v;
  end

  assign bus.rsp_valid = stage[LAT-1].v;
  assign bus.rsp_id    = stage[LAT-1].id[IDW-1:0];
  assign bus.rsp_sum   = bus.add_sum;
  assign idle          = ~inflight & ~(|bus.req_ready);
  assign dbg_ptr       = ptr;

endmodule
